// File: rtl/hs_npu_mem_sequencer_if.sv
// Memory-side bus between hs_npu_mem_sequencer and hs_npu_memory_interface.
// The _i/_o suffixes are from the sequencer's point of view.
interface hs_npu_mem_sequencer_if #(
    parameter int BURST_SIZE = 2
);
    logic                      mem_ready_i;
    logic                      mem_valid_i;
    logic                      mem_read_ready_o;
    logic                      mem_write_valid_o;
    logic                      mem_invalidate_o;
    logic [31:0]               request_address_o;
    logic [32*BURST_SIZE-1:0]  memory_data_o;
    logic [32*BURST_SIZE-1:0]  memory_data_i;

    modport master (
        input  mem_ready_i, mem_valid_i, memory_data_i,
        output mem_read_ready_o, mem_write_valid_o, mem_invalidate_o,
        output request_address_o, memory_data_o
    );

    modport slave (
        output mem_ready_i, mem_valid_i, memory_data_i,
        input  mem_read_ready_o, mem_write_valid_o, mem_invalidate_o,
        input  request_address_o, memory_data_o
    );
endinterface

// File: rtl/hs_npu_mem_sequencer.sv
// Burst read/write job sequencer in front of hs_npu_memory_interface; one memory op in flight at a time.
// Optional HS_NPU_MEMSEQ_STATS_EN adds mem_stall_cycles_o (cycles spent in M_RD/M_WR, saturating).
module hs_npu_mem_sequencer #(
    parameter int BURST_SIZE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_start_i,
    input  logic [31:0]              rd_base_i,
    input  logic [CNT_W-1:0]         rd_bursts_i,
    output logic [32*BURST_SIZE-1:0] rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     rd_busy_o,
    output logic                     rd_done_o,
    input  logic                     flush_i,
    input  logic                     wr_start_i,
    input  logic [31:0]              wr_base_i,
    input  logic [CNT_W-1:0]         wr_bursts_i,
    input  logic [32*BURST_SIZE-1:0] wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic                     wr_busy_o,
    output logic                     wr_done_o,
    hs_npu_mem_sequencer_if.master   mem
`ifdef HS_NPU_MEMSEQ_STATS_EN
    ,
    output logic [31:0]              mem_stall_cycles_o
`endif
);
    localparam int          DW        = 32 * BURST_SIZE;
    localparam logic [31:0] ADDR_STEP = 32'(4 * BURST_SIZE);

    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_RD, M_WR} m_state_e;

    m_state_e          m_state_q, m_state_d;
    logic              op_wr_q, op_wr_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [DW-1:0]     mem_data_q, mem_data_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_busy_q, rd_busy_d;
    logic [CNT_W-1:0]  rd_rem_q, rd_rem_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_done_q, rd_done_d;
    logic              flush_pend_q, flush_pend_d;
    logic              wr_busy_q, wr_busy_d;
    logic [CNT_W-1:0]  wr_rem_q, wr_rem_d;
    logic [31:0]       wr_addr_q, wr_addr_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_hs;
    logic              rd_in_flight;

    assign rd_hs        = rd_valid_q & rd_ready_i;
    assign rd_in_flight = ((m_state_q == M_SETUP) || (m_state_q == M_RD)) && !op_wr_q;
    // Only accept as many bursts as the job still owes, so a zero-count job never writes.
    assign wr_ready_o   = wr_busy_q & ~hold_full_q & (wr_rem_q != '0);

    always_comb begin
        m_state_d    = m_state_q;
        op_wr_d      = op_wr_q;
        req_addr_d   = req_addr_q;
        mem_data_d   = mem_data_q;
        rd_req_d     = rd_req_q;
        wr_req_d     = wr_req_q;
        rd_busy_d    = rd_busy_q;
        rd_rem_d     = rd_rem_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        flush_pend_d = flush_pend_q;
        wr_busy_d    = wr_busy_q;
        wr_rem_d     = wr_rem_q;
        wr_addr_d    = wr_addr_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;

        if (rd_start_i && !rd_busy_q) begin
            rd_busy_d = 1'b1;
            rd_rem_d  = rd_bursts_i;
            rd_addr_d = rd_base_i;
        end
        if (wr_start_i && !wr_busy_q) begin
            wr_busy_d = 1'b1;
            wr_rem_d  = wr_bursts_i;
            wr_addr_d = wr_base_i;
        end
        if (rd_hs) rd_valid_d = 1'b0;
        if (wr_valid_i && wr_ready_o) begin
            hold_d      = wr_data_i;
            hold_full_d = 1'b1;
        end
        if (flush_i && rd_busy_q) begin
            rd_rem_d   = '0;
            rd_valid_d = 1'b0;
            if (rd_in_flight) flush_pend_d = 1'b1;
        end

        case (m_state_q)
            M_IDLE: begin
                if (hold_full_q) begin
                    op_wr_d    = 1'b1;
                    req_addr_d = wr_addr_q;
                    mem_data_d = hold_q;
                    m_state_d  = M_SETUP;
                end else if (rd_rem_q != '0 && !rd_valid_q && !flush_i && !flush_pend_q) begin
                    op_wr_d    = 1'b0;
                    req_addr_d = rd_addr_q;
                    m_state_d  = M_SETUP;
                end
            end
            M_SETUP: begin
                if (op_wr_q) begin
                    wr_req_d  = 1'b1;
                    m_state_d = M_WR;
                end else begin
                    rd_req_d  = 1'b1;
                    m_state_d = M_RD;
                end
            end
            M_RD: begin
                if (mem.mem_valid_i) begin
                    rd_req_d     = 1'b0;
                    flush_pend_d = 1'b0;
                    m_state_d    = M_IDLE;
                    if (!flush_pend_q && !flush_i) begin
                        rd_data_d  = mem.memory_data_i;
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rd_addr_q + ADDR_STEP;
                        rd_rem_d   = rd_rem_q - CNT_W'(1);
                    end
                end
            end
            M_WR: begin
                if (mem.mem_ready_i) begin
                    wr_req_d    = 1'b0;
                    hold_full_d = 1'b0;
                    wr_addr_d   = wr_addr_q + ADDR_STEP;
                    wr_rem_d    = wr_rem_q - CNT_W'(1);
                    m_state_d   = M_IDLE;
                end
            end
            default: m_state_d = M_IDLE;
        endcase

        // Done is judged on next-cycle state so the pulse lands one cycle after the final handshake.
        rd_done_d = rd_busy_q && (rd_rem_d == '0) && !rd_valid_d &&
                    !(((m_state_d == M_SETUP) || (m_state_d == M_RD)) && !op_wr_d);
        wr_done_d = wr_busy_q && (wr_rem_d == '0) && !hold_full_d &&
                    !(((m_state_d == M_SETUP) || (m_state_d == M_WR)) && op_wr_d);
        if (rd_done_d) rd_busy_d = 1'b0;
        if (wr_done_d) wr_busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state_q    <= M_IDLE;
            op_wr_q      <= 1'b0;
            req_addr_q   <= '0;
            mem_data_q   <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_busy_q    <= 1'b0;
            rd_rem_q     <= '0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            wr_busy_q    <= 1'b0;
            wr_rem_q     <= '0;
            wr_addr_q    <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            m_state_q    <= m_state_d;
            op_wr_q      <= op_wr_d;
            req_addr_q   <= req_addr_d;
            mem_data_q   <= mem_data_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            rd_busy_q    <= rd_busy_d;
            rd_rem_q     <= rd_rem_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_done_q    <= rd_done_d;
            flush_pend_q <= flush_pend_d;
            wr_busy_q    <= wr_busy_d;
            wr_rem_q     <= wr_rem_d;
            wr_addr_q    <= wr_addr_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            wr_done_q    <= wr_done_d;
        end
    end

`ifdef HS_NPU_MEMSEQ_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((rd_start_i || wr_start_i) && !rd_busy_q && !wr_busy_q) begin
            stall_d = '0;
        end else if (((m_state_q == M_RD) || (m_state_q == M_WR)) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign mem_stall_cycles_o = stall_q;
`endif

    assign rd_data_o              = rd_data_q;
    assign rd_valid_o             = rd_valid_q;
    assign rd_busy_o              = rd_busy_q;
    assign rd_done_o              = rd_done_q;
    assign wr_busy_o              = wr_busy_q;
    assign wr_done_o              = wr_done_q;
    assign mem.mem_read_ready_o   = rd_req_q & ~mem.mem_valid_i;
    assign mem.mem_write_valid_o  = wr_req_q;
    assign mem.mem_invalidate_o   = 1'b0;
    assign mem.request_address_o  = req_addr_q;
    assign mem.memory_data_o      = mem_data_q;
endmodule

// File: tb/tb_hs_npu_mem_sequencer.sv
// Directed bench for hs_npu_mem_sequencer with a small memory-interface responder model.
module tb_hs_npu_mem_sequencer;
    localparam int          BS  = 2;
    localparam int          DW  = 32 * BS;
    localparam int          CW  = 16;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_start_i, rd_ready_i, flush_i, wr_start_i, wr_valid_i;
    logic [31:0]   rd_base_i, wr_base_i;
    logic [CW-1:0] rd_bursts_i, wr_bursts_i;
    logic [DW-1:0] rd_data_o, wr_data_i;
    logic          rd_valid_o, rd_busy_o, rd_done_o, wr_ready_o, wr_busy_o, wr_done_o;
`ifdef HS_NPU_MEMSEQ_STATS_EN
    logic [31:0]   stall_cycles;
`endif

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    hs_npu_mem_sequencer_if #(.BURST_SIZE(BS)) mem_if();

    hs_npu_mem_sequencer #(.BURST_SIZE(BS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_bursts_i(rd_bursts_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_busy_o(rd_busy_o), .rd_done_o(rd_done_o), .flush_i(flush_i),
        .wr_start_i(wr_start_i), .wr_base_i(wr_base_i), .wr_bursts_i(wr_bursts_i),
        .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_busy_o(wr_busy_o), .wr_done_o(wr_done_o),
        .mem(mem_if)
`ifdef HS_NPU_MEMSEQ_STATS_EN
        , .mem_stall_cycles_o(stall_cycles)
`endif
    );

    // Responder: accepts a request, answers 3 cycles later, then ignores the bus for one cycle.
    int          rdReqCnt = 0;
    int          wrReqCnt = 0;
    int          opCnt = 0;
    logic [31:0] rdReqAddr [64];
    logic [31:0] wrReqAddr [64];
    logic [63:0] wrReqData [64];
    logic        opIsWr    [64];
    logic        modelBusy, modelCool, modelIsRd;
    int          modelWait;
    logic [31:0] modelAddr;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_if.mem_valid_i   <= 1'b0;
            mem_if.mem_ready_i   <= 1'b0;
            mem_if.memory_data_i <= '0;
            modelBusy <= 1'b0;
            modelCool <= 1'b0;
            modelIsRd <= 1'b0;
            modelWait <= 0;
            modelAddr <= '0;
        end else begin
            mem_if.mem_valid_i <= 1'b0;
            mem_if.mem_ready_i <= 1'b0;
            if (modelBusy) begin
                if (modelWait == 0) begin
                    modelBusy <= 1'b0;
                    modelCool <= 1'b1;
                    if (modelIsRd) begin
                        mem_if.mem_valid_i   <= 1'b1;
                        mem_if.memory_data_i <= {(modelAddr + 32'd4) ^ KEY, modelAddr ^ KEY};
                    end else begin
                        mem_if.mem_ready_i <= 1'b1;
                    end
                end else begin
                    modelWait <= modelWait - 1;
                end
            end else if (modelCool) begin
                modelCool <= 1'b0;
            end else if (mem_if.mem_read_ready_o && rdReqCnt < 64 && opCnt < 64) begin
                modelBusy <= 1'b1;
                modelIsRd <= 1'b1;
                modelWait <= 2;
                modelAddr <= mem_if.request_address_o;
                rdReqAddr[rdReqCnt] <= mem_if.request_address_o;
                rdReqCnt <= rdReqCnt + 1;
                opIsWr[opCnt] <= 1'b0;
                opCnt <= opCnt + 1;
            end else if (mem_if.mem_write_valid_o && wrReqCnt < 64 && opCnt < 64) begin
                modelBusy <= 1'b1;
                modelIsRd <= 1'b0;
                modelWait <= 2;
                modelAddr <= mem_if.request_address_o;
                wrReqAddr[wrReqCnt] <= mem_if.request_address_o;
                wrReqData[wrReqCnt] <= mem_if.memory_data_o;
                wrReqCnt <= wrReqCnt + 1;
                opIsWr[opCnt] <= 1'b1;
                opCnt <= opCnt + 1;
            end
        end
    end

    // Observers sampled on the falling edge, away from the active edge.
    int          rdBeats = 0, rdDoneCnt = 0, wrDoneCnt = 0;
    int          overlapCnt = 0, rdValidCycles = 0, memReqCycles = 0;
    logic [63:0] rdBeatData [64];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid_o && rd_ready_i && rdBeats < 64) begin
                rdBeatData[rdBeats] = rd_data_o;
                rdBeats = rdBeats + 1;
            end
            if (rd_valid_o) rdValidCycles = rdValidCycles + 1;
            if (rd_done_o) rdDoneCnt = rdDoneCnt + 1;
            if (wr_done_o) wrDoneCnt = wrDoneCnt + 1;
            if (mem_if.mem_read_ready_o && mem_if.mem_write_valid_o) overlapCnt = overlapCnt + 1;
            if (mem_if.mem_read_ready_o || mem_if.mem_write_valid_o) memReqCycles = memReqCycles + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic doRd, input logic [31:0] rdBase, input logic [CW-1:0] rdBursts,
                                 input logic doWr, input logic [31:0] wrBase, input logic [CW-1:0] wrBursts);
        rd_start_i  = doRd;
        rd_base_i   = rdBase;
        rd_bursts_i = rdBursts;
        wr_start_i  = doWr;
        wr_base_i   = wrBase;
        wr_bursts_i = wrBursts;
        tick();
        rd_start_i = 1'b0;
        wr_start_i = 1'b0;
    endtask

    task automatic pushWrite(input logic [63:0] data);
        logic ok;
        ok = 1'b0;
        wr_data_i  = data;
        wr_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (wr_ready_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        wr_valid_i = 1'b0;
        checkOutput("wr_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic waitRdDone(input int baseCnt);
        for (int i = 0; i < 300 && rdDoneCnt <= baseCnt; i++) tick();
        checkOutput("rd_done_seen", {63'd0, rdDoneCnt > baseCnt}, 64'd1);
    endtask

    task automatic waitWrDone(input int baseCnt);
        for (int i = 0; i < 300 && wrDoneCnt <= baseCnt; i++) tick();
        checkOutput("wr_done_seen", {63'd0, wrDoneCnt > baseCnt}, 64'd1);
    endtask

    initial begin
        int rb, wb, bb, db, wdb, ob, ovb, vb, mb;
        logic seen;
        rd_start_i = 0; rd_base_i = 0; rd_bursts_i = 0; rd_ready_i = 1; flush_i = 0;
        wr_start_i = 0; wr_base_i = 0; wr_bursts_i = 0; wr_data_i = 0; wr_valid_i = 0;

        repeat (3) tick();
        checkOutput("rst_rd_busy", 64'(rd_busy_o), 64'd0);
        checkOutput("rst_rd_valid", 64'(rd_valid_o), 64'd0);
        checkOutput("rst_wr_ready", 64'(wr_ready_o), 64'd0);
        checkOutput("rst_req_addr", 64'(mem_if.request_address_o), 64'd0);
        checkOutput("rst_read_ready", 64'(mem_if.mem_read_ready_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] read job 0x1000 x3");
        rb = rdReqCnt; bb = rdBeats; db = rdDoneCnt;
        applyStimulus(1'b1, 32'h1000, 16'd3, 1'b0, 32'h0, 16'd0);
        waitRdDone(db);
        repeat (3) tick();
        checkOutput("rd1_req_count", 64'(rdReqCnt - rb), 64'd3);
        checkOutput("rd1_addr0", 64'(rdReqAddr[rb]), 64'h1000);
        checkOutput("rd1_addr1", 64'(rdReqAddr[rb+1]), 64'h1008);
        checkOutput("rd1_addr2", 64'(rdReqAddr[rb+2]), 64'h1010);
        checkOutput("rd1_beats", 64'(rdBeats - bb), 64'd3);
        checkOutput("rd1_data0", rdBeatData[bb], {32'hC0DE1004, 32'hC0DE1000});
        checkOutput("rd1_data2", rdBeatData[bb+2], {32'hC0DE1014, 32'hC0DE1010});
        checkOutput("rd1_done_count", 64'(rdDoneCnt - db), 64'd1);

        $display("[TB] write job 0x2000 x2");
        wb = wrReqCnt; wdb = wrDoneCnt;
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, 32'h2000, 16'd2);
        pushWrite(64'h1111_2222_3333_4444);
        pushWrite(64'h5555_6666_7777_8888);
        waitWrDone(wdb);
        repeat (3) tick();
        checkOutput("wr1_req_count", 64'(wrReqCnt - wb), 64'd2);
        checkOutput("wr1_addr0", 64'(wrReqAddr[wb]), 64'h2000);
        checkOutput("wr1_addr1", 64'(wrReqAddr[wb+1]), 64'h2008);
        checkOutput("wr1_data0", wrReqData[wb], 64'h1111_2222_3333_4444);
        checkOutput("wr1_data1", wrReqData[wb+1], 64'h5555_6666_7777_8888);
        checkOutput("wr1_done_count", 64'(wrDoneCnt - wdb), 64'd1);

        $display("[TB] read backpressure 0x3000 x2");
        rd_ready_i = 1'b0;
        rb = rdReqCnt; db = rdDoneCnt;
        applyStimulus(1'b1, 32'h3000, 16'd2, 1'b0, 32'h0, 16'd0);
        repeat (20) tick();
        checkOutput("bp_req_held", 64'(rdReqCnt - rb), 64'd1);
        checkOutput("bp_valid_held", 64'(rd_valid_o), 64'd1);
        checkOutput("bp_data_held", rd_data_o, {32'hC0DE3004, 32'hC0DE3000});
        rd_ready_i = 1'b1;
        waitRdDone(db);
        checkOutput("bp_req_count", 64'(rdReqCnt - rb), 64'd2);
        checkOutput("bp_addr1", 64'(rdReqAddr[rb+1]), 64'h3008);

        $display("[TB] concurrent read and write");
        ob = opCnt; ovb = overlapCnt; db = rdDoneCnt; wdb = wrDoneCnt; wb = wrReqCnt;
        applyStimulus(1'b1, 32'h5000, 16'd2, 1'b0, 32'h0, 16'd0);
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1, 32'h6000, 16'd1);
        pushWrite(64'hAAAA_BBBB_CCCC_DDDD);
        waitRdDone(db);
        waitWrDone(wdb);
        checkOutput("cc_op_count", 64'(opCnt - ob), 64'd3);
        checkOutput("cc_op0_rd", 64'(opIsWr[ob]), 64'd0);
        checkOutput("cc_op1_wr", 64'(opIsWr[ob+1]), 64'd1);
        checkOutput("cc_op2_rd", 64'(opIsWr[ob+2]), 64'd0);
        checkOutput("cc_wr_addr", 64'(wrReqAddr[wb]), 64'h6000);
        checkOutput("cc_overlap", 64'(overlapCnt - ovb), 64'd0);

        $display("[TB] flush during first read of four");
        rb = rdReqCnt; bb = rdBeats; vb = rdValidCycles; db = rdDoneCnt;
        applyStimulus(1'b1, 32'h7000, 16'd4, 1'b0, 32'h0, 16'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_if.mem_read_ready_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("fl_read_issued", {63'd0, seen}, 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        waitRdDone(db);
        repeat (10) tick();
        checkOutput("fl_req_count", 64'(rdReqCnt - rb), 64'd1);
        checkOutput("fl_beats", 64'(rdBeats - bb), 64'd0);
        checkOutput("fl_valid_never", 64'(rdValidCycles - vb), 64'd0);
        checkOutput("fl_done_count", 64'(rdDoneCnt - db), 64'd1);
        checkOutput("fl_busy_clear", 64'(rd_busy_o), 64'd0);

        $display("[TB] zero-burst jobs");
        mb = memReqCycles;
        applyStimulus(1'b1, 32'h8000, 16'd0, 1'b1, 32'h9000, 16'd0);
        checkOutput("z_rd_busy", 64'(rd_busy_o), 64'd1);
        checkOutput("z_wr_busy", 64'(wr_busy_o), 64'd1);
        checkOutput("z_rd_done_early", 64'(rd_done_o), 64'd0);
        checkOutput("z_wr_ready", 64'(wr_ready_o), 64'd0);
        tick();
        checkOutput("z_rd_done", 64'(rd_done_o), 64'd1);
        checkOutput("z_wr_done", 64'(wr_done_o), 64'd1);
        checkOutput("z_rd_busy_off", 64'(rd_busy_o), 64'd0);
        tick();
        checkOutput("z_rd_done_pulse", 64'(rd_done_o), 64'd0);
        checkOutput("z_wr_done_pulse", 64'(wr_done_o), 64'd0);
        repeat (3) tick();
        checkOutput("z_no_mem_traffic", 64'(memReqCycles - mb), 64'd0);
        checkOutput("z_invalidate", 64'(mem_if.mem_invalidate_o), 64'd0);

        $display("[TB] address wrap");
        rb = rdReqCnt; bb = rdBeats; db = rdDoneCnt;
        applyStimulus(1'b1, 32'hFFFF_FFF8, 16'd2, 1'b0, 32'h0, 16'd0);
        waitRdDone(db);
        checkOutput("wrap_addr0", 64'(rdReqAddr[rb]), 64'hFFFF_FFF8);
        checkOutput("wrap_addr1", 64'(rdReqAddr[rb+1]), 64'h0);
        checkOutput("wrap_data1", rdBeatData[bb+1], {32'hC0DE0004, 32'hC0DE0000});

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
